serial_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 5-bit serial frame transmitter among N_REQ requesters.
- Frame format on the line: start bit 0, then 5 data bits LSB first, then stop bit 1.
- Captures the winning requester's word, issues a single-cycle start to the transmitter, holds the data stable for the whole frame, and signals completion back to the winner.
- Sits between the requester-side control logic and the serial transmitter; the transmitter runs on the same clk and reset.

---
 rtl/serial_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin owner selection for one shared serial frame transmitter: captures the
// winner's word, sequences start/busy/done with timeouts, and reports completion.
module serial_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = 5,
    parameter int START_TIMEOUT = 4,
    parameter int FRAME_MAX     = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [$clog2(N_REQ)-1:0] active_id,
    output logic                     busy_o,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    input  logic                     err_clr,
    output logic                     err_timeout
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMR_W = $clog2(START_TIMEOUT + FRAME_MAX + 1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] FRAME_LAST = TMR_W'(FRAME_MAX - 1);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_SENDING   = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               win_found_s;
    logic [ID_W-1:0]    win_id_s;
    logic [ID_W-1:0]    cand_s;
    logic [DATA_W-1:0]  win_data_s;
    logic               grant_ok_s;
    logic               err_set_s;
    logic [ID_W-1:0]    next_ptr_s;
    logic [N_REQ-1:0]   gnt_s;

    // Round-robin search from rr_ptr upward with wrap; first set request wins.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = {ID_W{1'b0}};
        cand_s      = {ID_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_data_s = req_data[win_id_s*DATA_W +: DATA_W];
        grant_ok_s = (state_q == S_IDLE) && !reset && !tx_busy && win_found_s;
        next_ptr_s = (active_id_q == LAST_ID) ? {ID_W{1'b0}} : active_id_q + ID_W'(1);
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= {TMR_W{1'b0}};
            rr_ptr_q    <= {ID_W{1'b0}};
            active_id_q <= {ID_W{1'b0}};
            tx_data_q   <= {DATA_W{1'b0}};
            done_q      <= {N_REQ{1'b0}};
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rr_ptr_q    <= rr_ptr_d;
            active_id_q <= active_id_d;
            tx_data_q   <= tx_data_d;
            done_q      <= done_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic; a timeout abandons the frame and skips past the failed owner.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id_q;
        tx_data_d   = tx_data_q;
        err_set_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_ok_s) begin
                    state_d     = S_START;
                    active_id_d = win_id_s;
                    tx_data_d   = win_data_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_SENDING;
                end else if (timer_q == START_LAST) begin
                    err_set_s = 1'b1;
                    rr_ptr_d  = next_ptr_s;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_SENDING: begin
                if (!tx_busy) begin
                    state_d = S_DONE;
                end else if (timer_q == FRAME_LAST) begin
                    err_set_s = 1'b1;
                    rr_ptr_d  = next_ptr_s;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                rr_ptr_d = next_ptr_s;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        timer_d = (state_d != state_q) ? {TMR_W{1'b0}} : timer_d;
    end

    // Output decode; gnt must appear in the deciding IDLE cycle, so it is not registered.
    always_comb begin
        gnt_s      = grant_ok_s ? onehot(win_id_s) : {N_REQ{1'b0}};
        tx_start_d = (state_d == S_START);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE) ? onehot(active_id_q) : {N_REQ{1'b0}};
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign gnt         = gnt_s;
    assign done        = done_q;
    assign active_id   = active_id_q;
    assign busy_o      = busy_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: behavioural 7-cycle transmitter, vector table,
// directed corner sequences and a randomized run against a timeline reference model.
module tb_serial_tx_arbiter;
    localparam int N = 4;
    localparam int W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt, done;
    logic [1:0]       active_id;
    logic             busy_o, tx_start, tx_busy, err_clr, err_timeout;
    logic [W-1:0]     tx_data;

    logic             tx_en, force_busy;
    logic [3:0]       x_cnt;
    logic [6:0]       x_sh;
    logic [2:0]       x_idx;
    logic             x_busy, line;
    logic [6:0]       frame_s;

    int total = 0;
    int bad   = 0;

    serial_tx_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .active_id(active_id), .busy_o(busy_o),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .err_clr(err_clr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Transmitter: latches the word on tx_start and is busy for 7 bit times.
    always @(posedge clk) begin
        if (reset) begin
            x_cnt <= 4'd0;
            x_sh  <= 7'h7F;
        end else if (x_cnt != 4'd0) begin
            x_cnt <= x_cnt - 4'd1;
        end else if (tx_start && tx_en) begin
            x_cnt <= 4'd7;
            x_sh  <= {1'b1, tx_data, 1'b0};
        end
    end
    assign x_busy  = (x_cnt != 4'd0);
    assign x_idx   = 3'(4'd7 - x_cnt);
    assign line    = x_busy ? x_sh[x_idx] : 1'b1;
    assign tx_busy = x_busy | force_busy;

    always @(negedge clk) begin
        if (x_busy) frame_s <= {line, frame_s[6:1]};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1; req = '0; force_busy = 1'b0; err_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_done(output logic [N-1:0] d);
        d = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            settle();
            if (done != '0) begin
                d = done;
                break;
            end
        end
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] rq;
        logic [N*W-1:0] dat;
        logic         fb;
        logic [N-1:0] exp_gnt;
        logic [W-1:0] exp_word;
    } vec_t;
    vec_t vt[10];

    typedef struct {
        int           cyc;
        logic [N-1:0] oh;
        logic [W-1:0] w;
    } exp_t;

    task automatic run_vec(input vec_t v);
        logic [N-1:0] d;
        if (v.rst) do_reset();
        step();
        req = v.rq; req_data = v.dat; force_busy = v.fb;
        settle();
        chk("vec_gnt", gnt, v.exp_gnt);
        if (v.exp_gnt != '0) begin
            step();
            req = '0;
            settle();
            chk("vec_start", tx_start, 1);
            chk("vec_txdata", tx_data, v.exp_word);
            wait_done(d);
            chk("vec_done", d, v.exp_gnt);
            chk("vec_frame", frame_s, {1'b1, v.exp_word, 1'b0});
        end else begin
            step();
            req = '0; force_busy = 1'b0;
            settle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] d, dsum;
        logic [7:0]   lseq;
        int           starts;
        int           gi[8], gc[8], di[8], dw[8];
        int           ng, nd, stab_bad;
        exp_t         exp_q[$];
        int           m_free, m_ptr, last_g;
        logic [N-1:0] r_req, exp_g, exp_d;
        logic [N*W-1:0] r_dat;

        reset = 1'b1; req = '0; req_data = '0; err_clr = 1'b0;
        force_busy = 1'b0; tx_en = 1'b1;

        vt[0] = '{1'b1, 4'b0001, {5'h00, 5'h00, 5'h00, 5'h15}, 1'b0, 4'b0001, 5'h15};
        vt[1] = '{1'b0, 4'b0001, {5'h00, 5'h00, 5'h00, 5'h0A}, 1'b0, 4'b0001, 5'h0A};
        vt[2] = '{1'b0, 4'b1111, {5'h1C, 5'h13, 5'h07, 5'h01}, 1'b0, 4'b0010, 5'h07};
        vt[3] = '{1'b0, 4'b1001, {5'h19, 5'h00, 5'h00, 5'h02}, 1'b0, 4'b1000, 5'h19};
        vt[4] = '{1'b0, 4'b1001, {5'h19, 5'h00, 5'h00, 5'h02}, 1'b0, 4'b0001, 5'h02};
        vt[5] = '{1'b0, 4'b1111, {5'h1C, 5'h13, 5'h07, 5'h01}, 1'b1, 4'b0000, 5'h00};
        vt[6] = '{1'b0, 4'b0110, {5'h00, 5'h0E, 5'h11, 5'h00}, 1'b0, 4'b0010, 5'h11};
        vt[7] = '{1'b0, 4'b0000, {5'h00, 5'h00, 5'h00, 5'h00}, 1'b0, 4'b0000, 5'h00};
        vt[8] = '{1'b0, 4'b1100, {5'h1F, 5'h10, 5'h00, 5'h00}, 1'b0, 4'b0100, 5'h10};
        vt[9] = '{1'b0, 4'b1011, {5'h05, 5'h00, 5'h06, 5'h1E}, 1'b0, 4'b1000, 5'h05};

        // reset values
        do_reset();
        step();
        settle();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_id", active_id, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_timeout, 0);

        for (int v = 0; v < 10; v++) run_vec(vt[v]);

        // A: single requester, full timeline and line sequence
        do_reset();
        step();
        req = 4'b0100; req_data = {5'h00, 5'b10110, 5'h00, 5'h00};
        settle();
        chk("A_gnt", gnt, 4'b0100);
        chk("A_busy_idle", busy_o, 0);
        lseq = '0; starts = 0; dsum = '0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 1) req = '0;
            settle();
            if (k <= 8) lseq = {lseq[6:0], line};
            if (k == 1) begin
                chk("A_start", tx_start, 1);
                chk("A_busy", busy_o, 1);
                chk("A_id", active_id, 2);
                chk("A_txdata", tx_data, 5'b10110);
            end else begin
                starts += int'(tx_start);
            end
            if (k == 10) chk("A_done", done, 4'b0100);
            else dsum |= done;
            if (k == 11) chk("A_busy_end", busy_o, 0);
        end
        chk("A_line", lseq, 8'b10011011);
        chk("A_one_start", starts, 0);
        chk("A_one_done", dsum, 0);

        // B: round-robin fairness with all requesters held
        do_reset();
        ng = 0; nd = 0;
        step();
        req = 4'b1111; req_data = {5'd4, 5'd3, 5'd2, 5'd1};
        for (int c = 0; c < 55; c++) begin
            if (c > 0) step();
            settle();
            for (int i = 0; i < N; i++) begin
                if (gnt[i] && ng < 8) begin gi[ng] = i; gc[ng] = c; ng++; end
                if (done[i] && nd < 8) begin di[nd] = i; dw[nd] = int'(frame_s[5:1]); nd++; end
            end
        end
        step();
        req = '0;
        settle();
        chk("B_ngrant", ng, 5);
        chk("B_ndone", nd, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < ng) chk("B_order", gi[k], k % 4);
            if (k < ng) chk("B_spacing", gc[k], 11 * k);
            if (k < nd) chk("B_done_id", di[k], k % 4);
            if (k < nd) chk("B_word", dw[k], k % 4 + 1);
        end

        // C: data stability after grant
        do_reset();
        step();
        req = 4'b0001; req_data = {15'h0, 5'h0A};
        settle();
        chk("C_gnt", gnt, 4'b0001);
        step();
        req = '0; req_data = {15'h0, 5'h1F};
        settle();
        stab_bad = 0; d = '0;
        for (int k = 0; k < 20; k++) begin
            if (tx_data !== 5'h0A) stab_bad++;
            step();
            settle();
            if (done != '0) begin d = done; break; end
        end
        chk("C_txdata_stable", stab_bad, 0);
        chk("C_done", d, 4'b0001);
        chk("C_frame", frame_s, {1'b1, 5'h0A, 1'b0});

        // D: start timeout, pointer skip, error does not block, clear collision, clear
        do_reset();
        tx_en = 1'b0;
        step();
        req = 4'b0010; req_data = {5'h00, 5'h00, 5'h0C, 5'h00};
        settle();
        chk("D_gnt", gnt, 4'b0010);
        dsum = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) req = '0;
            settle();
            dsum |= done;
            if (k == 5) chk("D_err_early", err_timeout, 0);
            if (k == 6) begin
                chk("D_err_set", err_timeout, 1);
                chk("D_idle", busy_o, 0);
            end
        end
        chk("D_no_done", dsum, 0);
        tx_en = 1'b1;
        step();
        req = 4'b0011; req_data = {5'h00, 5'h00, 5'h0C, 5'h03};
        settle();
        chk("D_ptr_gnt", gnt, 4'b0001);
        chk("D_err_kept", err_timeout, 1);
        step();
        req = '0;
        settle();
        wait_done(d);
        chk("D_done", d, 4'b0001);
        chk("D_frame", frame_s, {1'b1, 5'h03, 1'b0});
        tx_en = 1'b0;
        step();
        req = 4'b0100; req_data = {5'h00, 5'h12, 5'h00, 5'h00};
        settle();
        chk("D_gnt2", gnt, 4'b0100);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) req = '0;
            err_clr = (k == 5);
            settle();
            if (k == 6) chk("D_clr_collide", err_timeout, 1);
        end
        step();
        err_clr = 1'b1;
        settle();
        step();
        err_clr = 1'b0;
        settle();
        chk("D_clr", err_timeout, 0);
        tx_en = 1'b1;

        // E: reset mid-frame
        do_reset();
        step();
        req = 4'b1000; req_data = {5'h15, 15'h0};
        settle();
        chk("E_gnt", gnt, 4'b1000);
        dsum = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) reset = 1'b1;
            settle();
            dsum |= done;
        end
        chk("E_gnt_rst", gnt, 0);
        chk("E_done_rst", done, 0);
        chk("E_start_rst", tx_start, 0);
        chk("E_txdata_rst", tx_data, 0);
        chk("E_id_rst", active_id, 0);
        chk("E_busy_rst", busy_o, 0);
        chk("E_err_rst", err_timeout, 0);
        chk("E_no_done", dsum, 0);
        step();
        reset = 1'b0;
        settle();
        chk("E_regrant", gnt, 4'b1000);
        step();
        req = '0;
        settle();
        wait_done(d);
        chk("E_done", d, 4'b1000);

        // Random run against a timeline model
        do_reset();
        m_free = 0; m_ptr = 0; last_g = -100;
        r_req = '0; r_dat = '0;
        for (int c = 0; c < 600; c++) begin
            step();
            req = r_req; req_data = r_dat;
            force_busy = (c >= m_free) && ($urandom_range(0, 3) == 0);
            settle();
            exp_g = '0;
            if (c >= m_free && !force_busy && r_req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (exp_g == '0 && r_req[(m_ptr + k) % N]) begin
                        exp_g = 4'b0001 << ((m_ptr + k) % N);
                        exp_q.push_back('{c + 10, exp_g, r_dat[((m_ptr + k) % N) * W +: W]});
                        m_ptr = (m_ptr + k + 1) % N;
                    end
                end
                m_free = c + 11;
                last_g = c;
            end
            exp_d = '0;
            if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                exp_d = exp_q[0].oh;
                chk("rnd_frame", frame_s, {1'b1, exp_q[0].w, 1'b0});
                void'(exp_q.pop_front());
            end
            chk("rnd_gnt", gnt, exp_g);
            chk("rnd_done", done, exp_d);
            chk("rnd_busy", busy_o, (c > last_g) && (c < m_free));
            chk("rnd_err", err_timeout, 0);
            for (int i = 0; i < N; i++) begin
                if (exp_g[i]) begin
                    if ($urandom_range(0, 1) == 0) r_req[i] = 1'b0;
                    r_dat[i*W +: W] = W'($urandom);
                end else if (!r_req[i] && $urandom_range(0, 5) == 0) begin
                    r_req[i] = 1'b1;
                    r_dat[i*W +: W] = W'($urandom);
                end
            end
            if (c >= 580) r_req = '0;
        end
        chk("rnd_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
